// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, MIPS-style results
// (lo = quotient, hi = remainder) with signed/unsigned, early-out and divide-by-zero handling.
module divider_iter #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             out_valid_q;
    logic             dbz_q;

    logic             dnd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dnd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;

    always_comb begin
        dnd_neg = is_signed & dividend[WIDTH-1];
        dsr_neg = is_signed & divisor[WIDTH-1];
        dnd_mag = dnd_neg ? (~dividend + 1'b1) : dividend;
        dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;

        // No borrow out of the widened subtraction means the shifted remainder >= divisor.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {2'b00, dsr_q};
        ge      = ~diff[WIDTH+1];
        rem_d   = ge ? diff[WIDTH:0] : shifted[WIDTH:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};

        lo_fix  = q_neg_q ? (~quo_d + 1'b1) : quo_d;
        hi_fix  = r_neg_q ? (~rem_d[WIDTH-1:0] + 1'b1) : rem_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            lo_q        <= '1;
                            hi_q        <= dividend;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (EARLY_OUT && (dnd_mag < dsr_mag)) begin
                            lo_q        <= '0;
                            hi_q        <= dividend;
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dnd_mag;
                            dsr_q   <= dsr_mag;
                            q_neg_q <= dnd_neg ^ dsr_neg;
                            r_neg_q <= dnd_neg;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last quotient bit lands this edge, so sign fix-up happens together with it.
                    if (cnt_q == CW'(1)) begin
                        lo_q        <= lo_fix;
                        hi_q        <= hi_fix;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter (WIDTH=32): early-out instance plus an always-iterate instance.
module tb_divider_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_ready = 1'b0;
    logic        out_ready1 = 1'b0;
    logic        in_ready, out_valid, div_by_zero;
    logic        in_ready1, out_valid1, div_by_zero1;
    logic [31:0] hi, lo, hi1, lo1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    divider_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    divider_iter #(.WIDTH(32), .EARLY_OUT(1'b0)) u_dut_noeo (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .hi(hi1), .lo(lo1), .div_by_zero(div_by_zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure latency from the accept edge, check the result, then retire it.
    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_dbz);
        int lat;
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        $display("[TB] op %s a=%h b=%h s=%0d lat=%0d lo=%h hi=%h dbz=%0d",
                 tag, a, b, sgn, lat, lo, hi, div_by_zero);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " in_ready after handoff"}, {31'b0, in_ready}, 32'd1);
        chk({tag, " out_valid after handoff"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Main function
        run_op("u100/7",      1'b0, 32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);
        run_op("s-7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("sMIN/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0,          1'b0);
        run_op("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9,  32'd2,          33, 32'h7FFF_FFFC,  32'd1,          1'b0);
        run_op("u10/10",      1'b0, 32'd10,         32'd10,         33, 32'd1,          32'd0,          1'b0);
        run_op("u5/0",        1'b0, 32'd5,          32'd0,          1,  32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s5/0",        1'b1, 32'd5,          32'd0,          1,  32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s-5/0",       1'b1, 32'hFFFF_FFFB,  32'd0,          1,  32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
        run_op("u3/10 early", 1'b0, 32'd3,          32'd10,         1,  32'd0,          32'd3,          1'b0);
        run_op("s-3/10 early",1'b1, 32'hFFFF_FFFD,  32'd10,         1,  32'd0,          32'hFFFF_FFFD,  1'b0);

        // Same 3/10 on the always-iterate instance
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd3;
        divisor   = 32'd10;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("noeo 3/10 latency", 32'(lat), 32'd33);
        chk("noeo 3/10 lo", lo1, 32'd0);
        chk("noeo 3/10 hi", hi1, 32'd3);
        $display("[TB] op noeo u3/10 lat=%0d lo=%h hi=%h", lat, lo1, hi1);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        chk("noeo in_ready after handoff", {31'b0, in_ready1}, 32'd1);

        // Hold result in DONE with out_ready low
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold lo", lo, 32'd14);
            chk("hold hi", hi, 32'd2);
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        $display("[TB] op hold 5 cycles lo=%h hi=%h in_ready=%0d", lo, hi, in_ready);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold release in_ready", {31'b0, in_ready}, 32'd1);
        chk("hold release out_valid", {31'b0, out_valid}, 32'd0);

        // Flush at t+10 of a BUSY op
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy in_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush out_valid", {31'b0, out_valid}, 32'd0);
        $display("[TB] op flush busy in_ready=%0d out_valid=%0d", in_ready, out_valid);
        run_op("u9/3 after flush", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

        // Flush in DONE drops a pending result
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 32'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done before flush out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush done out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush done in_ready", {31'b0, in_ready}, 32'd1);
        $display("[TB] op flush done out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Reset mid-BUSY
        run_op("u9/3 again", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("busy reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("busy reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("busy reset hi", hi, 32'd0);
        chk("busy reset lo", lo, 32'd0);
        chk("busy reset dbz", {31'b0, div_by_zero}, 32'd0);
        $display("[TB] op reset mid-busy in_ready=%0d out_valid=%0d lo=%h hi=%h",
                 in_ready, out_valid, lo, hi);
        repeat (40) @(posedge clk);
        #1;
        chk("post reset out_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
